matmul_apb_slave: RTL and testbench

MATMUL_APB_SLAVE -- requirements
Module: matmul_apb_slave

---
 rtl/matmul_pkg.sv | 31 +++
 rtl/matmul_apb_slave_if.sv | 26 ++
 rtl/matmul_operand_bank.sv | 31 +++
 rtl/matmul_apb_slave.sv | 168 ++++++++++++++++
 tb/tb_matmul_apb_slave.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, register map and FSM encoding for the matmul APB slave.
package matmul_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int BUS_WIDTH  = 32;
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
   localparam int ADDR_WIDTH = 32;

   localparam logic [4:0] ADDR_CONTROL   = 5'h00;
   localparam logic [4:0] ADDR_OPERAND_A = 5'h04;
   localparam logic [4:0] ADDR_OPERAND_B = 5'h08;
   localparam logic [4:0] ADDR_FLAGS     = 5'h0C;
   localparam logic [4:0] ADDR_SP0       = 5'h10;
   localparam logic [4:0] ADDR_SP1       = 5'h14;
   localparam logic [4:0] ADDR_SP2       = 5'h18;
   localparam logic [4:0] ADDR_SP3       = 5'h1C;

   // start (bit 0) is self-clearing, so it is never stored
   localparam logic [15:0] CTRL_WMASK = 16'h3F3E;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      SP_WAIT
   } apb_state_e;

   function automatic logic is_sp_region(input logic [4:0] region);
      return (region == ADDR_SP0) || (region == ADDR_SP1) ||
             (region == ADDR_SP2) || (region == ADDR_SP3);
   endfunction
endpackage

// File: rtl/matmul_apb_slave_if.sv
// APB bus bundle between the host and the matmul register slave.
interface matmul_apb_slave_if #(
   parameter int ADDR_WIDTH = matmul_pkg::ADDR_WIDTH,
   parameter int BUS_WIDTH  = matmul_pkg::BUS_WIDTH,
   parameter int MAX_DIM    = matmul_pkg::MAX_DIM
);
   logic                  psel_i;
   logic                  penable_i;
   logic                  pwrite_i;
   logic [MAX_DIM-1:0]    pstrb_i;
   logic [ADDR_WIDTH-1:0] paddr_i;
   logic [BUS_WIDTH-1:0]  pwdata_i;
   logic [BUS_WIDTH-1:0]  prdata_o;
   logic                  pready_o;
   logic                  pslverr_o;

   modport slave (
      input  psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
      output prdata_o, pready_o, pslverr_o
   );

   modport master (
      output psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
      input  prdata_o, pready_o, pslverr_o
   );
endinterface

// File: rtl/matmul_operand_bank.sv
// MAX_DIM operand rows, each written lane-by-lane under byte strobes.
module matmul_operand_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 32,
   parameter int MAX_DIM    = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         we_i,
   input  logic [$clog2(MAX_DIM)-1:0]   line_i,
   input  logic [MAX_DIM-1:0]           strb_i,
   input  logic [BUS_WIDTH-1:0]         wdata_i,
   output logic [BUS_WIDTH*MAX_DIM-1:0] rows_o
);
   logic [BUS_WIDTH-1:0] row_q [MAX_DIM];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int r = 0; r < MAX_DIM; r++) row_q[r] <= '0;
      end else if (we_i) begin
         for (int l = 0; l < MAX_DIM; l++) begin
            if (strb_i[l])
               row_q[line_i][l*DATA_WIDTH +: DATA_WIDTH] <= wdata_i[l*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar r = 0; r < MAX_DIM; r++) begin : g_rows
      assign rows_o[r*BUS_WIDTH +: BUS_WIDTH] = row_q[r];
   end
endmodule

// File: rtl/matmul_apb_slave.sv
// APB register front-end of the matmul core: control, operands, flags, scratchpad reads.
//   state   | meaning
//   IDLE    | no transfer, waiting for a setup phase
//   SETUP   | address phase seen, waiting for penable
//   ACCESS  | pready_o cycle, transfer completes
//   SP_WAIT | scratchpad read issued, data returns next cycle
module matmul_apb_slave #(
   parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
   parameter int BUS_WIDTH  = matmul_pkg::BUS_WIDTH,
   parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   parameter int ADDR_WIDTH = matmul_pkg::ADDR_WIDTH
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   matmul_apb_slave_if.slave              apb,
   output logic                           busy_o,
   output logic                           start_o,
   output logic [15:0]                    control_o,
   output logic [BUS_WIDTH*MAX_DIM-1:0]   operand_a_o,
   output logic [BUS_WIDTH*MAX_DIM-1:0]   operand_b_o,
   input  logic                           done_i,
   input  logic [BUS_WIDTH-1:0]           flags_i,
   output logic                           sp_rd_o,
   output logic [1:0]                     sp_sel_o,
   output logic [2*$clog2(MAX_DIM)-1:0]   sp_addr_o,
   input  logic [BUS_WIDTH-1:0]           sp_rdata_i
);
   import matmul_pkg::*;

   localparam int LINE_W = $clog2(MAX_DIM);
   localparam int SP_AW  = 2 * LINE_W;

   apb_state_e state_q, state_d;
   logic pready_q, pready_d, pslverr_q, rd_en_q, rd_en_d;
   logic start_req_q, start_q, busy_q, sp_rd_q;
   logic [4:0] rd_region_q;
   logic [LINE_W-1:0] rd_line_q;
   logic [15:0] ctrl_q;
   logic [1:0] sp_sel_q;
   logic [SP_AW-1:0] sp_addr_q;
   logic [BUS_WIDTH-1:0] prdata;

   logic [4:0] region;
   logic [LINE_W-1:0] line;
   logic acc_req, is_sp, xfer_err, sp_rd_req, wr_ok, ctrl_we;
   logic unused_addr;

   assign region      = {apb.paddr_i[4:2], 2'b00};
   assign line        = apb.paddr_i[5 +: LINE_W];
   assign unused_addr = ^apb.paddr_i;
   assign acc_req     = (state_q == SETUP) && apb.psel_i && apb.penable_i;
   assign is_sp       = is_sp_region(region);
   assign xfer_err    = (|apb.paddr_i[1:0]) ||
                        (apb.pwrite_i && (busy_q || region == ADDR_FLAGS || is_sp));
   assign sp_rd_req   = acc_req && !apb.pwrite_i && is_sp && !xfer_err;
   assign wr_ok       = acc_req && apb.pwrite_i && !xfer_err;
   assign ctrl_we     = wr_ok && (region == ADDR_CONTROL);

   always_comb begin
      state_d  = state_q;
      pready_d = 1'b0;
      case (state_q)
         IDLE:    if (apb.psel_i && !apb.penable_i) state_d = SETUP;
         SETUP: begin
            if (!apb.psel_i) begin
               state_d = IDLE;
            end else if (apb.penable_i) begin
               state_d  = sp_rd_req ? SP_WAIT : ACCESS;
               pready_d = !sp_rd_req;
            end
         end
         SP_WAIT: begin
            if (!apb.psel_i) begin
               state_d = IDLE;
            end else begin
               state_d  = ACCESS;
               pready_d = 1'b1;
            end
         end
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rd_en_d = pready_d && !apb.pwrite_i && !xfer_err;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_region_q <= '0;
         rd_line_q   <= '0;
         start_req_q <= 1'b0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         ctrl_q      <= '0;
         sp_rd_q     <= 1'b0;
         sp_sel_q    <= '0;
         sp_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         pready_q    <= pready_d;
         rd_en_q     <= rd_en_d;
         rd_region_q <= region;
         rd_line_q   <= line;
         if (state_q == IDLE && state_d == SETUP) pslverr_q <= 1'b0;
         else if (state_q == SETUP && pready_d)   pslverr_q <= xfer_err;

         // scratchpad request is held only for its strobe cycle
         sp_rd_q   <= sp_rd_req;
         sp_sel_q  <= sp_rd_req ? apb.paddr_i[3:2] : 2'b00;
         sp_addr_q <= sp_rd_req ? apb.paddr_i[5 +: SP_AW] : '0;

         if (ctrl_we) begin
            for (int l = 0; l < 2; l++) begin
               if (apb.pstrb_i[l])
                  ctrl_q[l*8 +: 8] <= apb.pwdata_i[l*8 +: 8] & CTRL_WMASK[l*8 +: 8];
            end
         end
         start_req_q <= ctrl_we && apb.pstrb_i[0] && apb.pwdata_i[0];
         start_q     <= start_req_q;
         if (start_req_q)  busy_q <= 1'b1;
         else if (done_i)  busy_q <= 1'b0;
      end
   end

   always_comb begin
      prdata = '0;
      if (rd_en_q) begin
         if (rd_region_q == ADDR_CONTROL)        prdata = BUS_WIDTH'(ctrl_q);
         else if (rd_region_q == ADDR_OPERAND_A) prdata = operand_a_o[rd_line_q*BUS_WIDTH +: BUS_WIDTH];
         else if (rd_region_q == ADDR_OPERAND_B) prdata = operand_b_o[rd_line_q*BUS_WIDTH +: BUS_WIDTH];
         else if (rd_region_q == ADDR_FLAGS)     prdata = flags_i;
         else                                    prdata = sp_rdata_i;
      end
   end

   matmul_operand_bank #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .MAX_DIM(MAX_DIM)) u_bank_a (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_ok && region == ADDR_OPERAND_A),
      .line_i  (line),
      .strb_i  (apb.pstrb_i),
      .wdata_i (apb.pwdata_i),
      .rows_o  (operand_a_o)
   );

   matmul_operand_bank #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH), .MAX_DIM(MAX_DIM)) u_bank_b (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_ok && region == ADDR_OPERAND_B),
      .line_i  (line),
      .strb_i  (apb.pstrb_i),
      .wdata_i (apb.pwdata_i),
      .rows_o  (operand_b_o)
   );

   assign apb.prdata_o  = prdata;
   assign apb.pready_o  = pready_q;
   assign apb.pslverr_o = pslverr_q;
   assign busy_o        = busy_q;
   assign start_o       = start_q;
   assign control_o     = ctrl_q;
   assign sp_rd_o       = sp_rd_q;
   assign sp_sel_o      = sp_sel_q;
   assign sp_addr_o     = sp_addr_q;
endmodule

// File: tb/tb_matmul_apb_slave.sv
// Scoreboard bench for matmul_apb_slave: APB transfers queue expectations, a monitor checks completions.
module tb_matmul_apb_slave;
   import matmul_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         busy_o, start_o, done_i, sp_rd_o;
   logic [15:0]  control_o;
   logic [127:0] operand_a_o, operand_b_o;
   logic [31:0]  flags_i, sp_rdata_i;
   logic [1:0]   sp_sel_o;
   logic [3:0]   sp_addr_o;

   int total = 0;
   int bad   = 0;
   int sp_pulses = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       tag;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk_i = ~clk_i;

   matmul_apb_slave_if apb ();

   matmul_apb_slave dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .apb         (apb),
      .busy_o      (busy_o),
      .start_o     (start_o),
      .control_o   (control_o),
      .operand_a_o (operand_a_o),
      .operand_b_o (operand_b_o),
      .done_i      (done_i),
      .flags_i     (flags_i),
      .sp_rd_o     (sp_rd_o),
      .sp_sel_o    (sp_sel_o),
      .sp_addr_o   (sp_addr_o),
      .sp_rdata_i  (sp_rdata_i)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err,
                           input string tag, input int exp_waits);
      int waits;
      exp_t e;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.tag   = tag;
      sb_q.push_back(e);
      @(posedge clk_i); #1;
      apb.psel_i    = 1'b1;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = wr;
      apb.paddr_i   = addr;
      apb.pwdata_i  = wdata;
      apb.pstrb_i   = strb;
      @(posedge clk_i); #1;
      apb.penable_i = 1'b1;
      waits = 0;
      for (int i = 1; i <= 10 && waits == 0; i++) begin
         @(negedge clk_i);
         if (apb.pready_o === 1'b1) waits = i;
      end
      chk({tag, " latency"}, waits, exp_waits);
      @(posedge clk_i); #1;
      apb.psel_i    = 1'b0;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = 1'b0;
      apb.pstrb_i   = '0;
      apb.pwdata_i  = '0;
      apb.paddr_i   = '0;
   endtask

   // completion monitor
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (apb.pready_o === 1'b1) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pready: got pready=1 expected no transfer");
            end else begin
               e = sb_q.pop_front();
               chk({e.tag, " prdata"}, apb.prdata_o, e.rdata);
               chk({e.tag, " pslverr"}, apb.pslverr_o, e.err);
            end
         end
      end
   end

   // scratchpad model: data depends on the requested entry, valid one cycle after the strobe
   initial begin : sp_model
      logic [1:0] sel;
      logic [3:0] addr;
      sp_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         if (sp_rd_o === 1'b1) begin
            sp_pulses++;
            sel  = sp_sel_o;
            addr = sp_addr_o;
            @(posedge clk_i); #1;
            sp_rdata_i = (sel == 2'd2 && addr == 4'd5) ? 32'hDEADBEEF : 32'h0BAD0BAD;
            @(posedge clk_i); #1;
            sp_rdata_i = '0;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      apb.psel_i = 0; apb.penable_i = 0; apb.pwrite_i = 0;
      apb.pstrb_i = '0; apb.paddr_i = '0; apb.pwdata_i = '0;
      done_i = 0;
      flags_i = 32'h5A5AC3C3;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst pready",  apb.pready_o, 0);
      chk("rst pslverr", apb.pslverr_o, 0);
      chk("rst prdata",  apb.prdata_o, 0);
      chk("rst busy",    busy_o, 0);
      chk("rst start",   start_o, 0);
      chk("rst control", control_o, 0);
      chk("rst op_a",    operand_a_o, 0);
      chk("rst op_b",    operand_b_o, 0);
      chk("rst sp_rd",   sp_rd_o, 0);
      chk("rst sp_sel",  sp_sel_o, 0);
      chk("rst sp_addr", sp_addr_o, 0);
      chk("rst state",   dut.state_q, IDLE);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // byte-strobed operand writes
      apb_xfer(1, 32'h44, 32'h04030201, 4'hF, 0, 0, "wr A2 full", 2);
      apb_xfer(1, 32'h44, 32'hFFFFFFFF, 4'h5, 0, 0, "wr A2 lanes", 2);
      chk("A row2", operand_a_o[64 +: 32], 32'h04FF02FF);
      apb_xfer(0, 32'h44, 0, 4'h0, 32'h04FF02FF, 0, "rd A2", 2);
      apb_xfer(1, 32'h28, 32'h11223344, 4'hF, 0, 0, "wr B1", 2);
      apb_xfer(0, 32'h28, 0, 4'h0, 32'h11223344, 0, "rd B1", 2);

      // start the core
      apb_xfer(1, 32'h00, 32'h00001503, 4'hF, 0, 0, "wr ctrl", 2);
      @(negedge clk_i);
      chk("start pulse", start_o, 1);
      chk("busy set", busy_o, 1);
      @(negedge clk_i);
      chk("start end", start_o, 0);
      chk("busy hold", busy_o, 1);
      chk("control_o", control_o, 16'h1502);
      apb_xfer(0, 32'h00, 0, 4'h0, 32'h00001502, 0, "rd ctrl", 2);

      // busy blocks operand writes until done
      apb_xfer(1, 32'h28, 32'hAAAAAAAA, 4'hF, 0, 1, "wr B1 busy", 2);
      @(negedge clk_i);
      chk("pslverr held", apb.pslverr_o, 1);
      chk("B row1 kept", operand_b_o[32 +: 32], 32'h11223344);
      @(posedge clk_i); #1; done_i = 1'b1;
      @(posedge clk_i); #1; done_i = 1'b0;
      @(negedge clk_i);
      chk("busy cleared", busy_o, 0);
      @(posedge clk_i); #1; done_i = 1'b1;
      @(posedge clk_i); #1; done_i = 1'b0;
      @(negedge clk_i);
      chk("done idle ignored", busy_o, 0);
      apb_xfer(1, 32'h28, 32'hAAAAAAAA, 4'hF, 0, 0, "wr B1 retry", 2);
      chk("B row1 new", operand_b_o[32 +: 32], 32'hAAAAAAAA);

      // flags and scratchpad reads
      apb_xfer(0, 32'h0C, 0, 4'h0, 32'h5A5AC3C3, 0, "rd flags", 2);
      apb_xfer(0, 32'hB8, 0, 4'h0, 32'hDEADBEEF, 0, "rd SP2 5", 3);
      chk("sp pulses", sp_pulses, 1);
      apb_xfer(0, 32'h10, 0, 4'h0, 32'h0BAD0BAD, 0, "rd SP0 0", 3);
      chk("sp pulses 2", sp_pulses, 2);

      // error cases
      apb_xfer(1, 32'h0C, 32'h12345678, 4'hF, 0, 1, "wr flags", 2);
      apb_xfer(1, 32'h14, 32'h12345678, 4'hF, 0, 1, "wr SP1", 2);
      apb_xfer(1, 32'h46, 32'h00000000, 4'hF, 0, 1, "wr A2 misaligned", 2);
      chk("A row2 kept", operand_a_o[64 +: 32], 32'h04FF02FF);
      chk("sp no pulse", sp_pulses, 2);

      // reset during the access phase aborts the transfer
      @(posedge clk_i); #1;
      apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0; apb.paddr_i = 32'h00;
      @(posedge clk_i); #1;
      apb.penable_i = 1'b1;
      rst_ni = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("abort pready", apb.pready_o, 0);
      chk("abort state", dut.state_q, IDLE);
      chk("abort control", control_o, 0);
      chk("abort op_a", operand_a_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      apb.psel_i = 1'b0; apb.penable_i = 1'b0;
      apb_xfer(0, 32'h44, 0, 4'h0, 32'h00000000, 0, "rd A2 post rst", 2);

      repeat (3) @(posedge clk_i);
      chk("scoreboard drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
